// File: rtl/arcade_video_timing_if.sv
// Video timing bus between the game core and the raster timing generator.
// The master side drives trims and pixel data; the slave side (the generator) drives timing outputs.
interface arcade_video_timing_if #(
    parameter int CW   = 9,
    parameter int RGBW = 12
);
    logic [3:0]      h_trim;
    logic [3:0]      v_trim;
    logic [RGBW-1:0] rgb_in;
    logic            pce;
    logic            pclk;
    logic [CW-1:0]   hpos;
    logic [CW-1:0]   vpos;
    logic [RGBW-1:0] rgb_out;
    logic            hblk;
    logic            vblk;
    logic            hsyn;
    logic            vsyn;
    logic            vbl_irq;
    logic            frame_odd;

    modport master (
        output h_trim, v_trim, rgb_in,
        input  pce, pclk, hpos, vpos, rgb_out, hblk, vblk, hsyn, vsyn, vbl_irq, frame_odd
    );

    modport slave (
        input  h_trim, v_trim, rgb_in,
        output pce, pclk, hpos, vpos, rgb_out, hblk, vblk, hsyn, vsyn, vbl_irq, frame_odd
    );
endinterface

// File: rtl/arcade_video_timing.sv
// Raster timing generator: pixel-enable divider, skip-count H/V counters with one jump each,
// registered blank/sync flags, blanked RGB, VBL interrupt and frame parity.
module arcade_video_timing #(
    parameter int CLK_DIV      = 8,
    parameter int CW           = 9,
    parameter int RGBW         = 12,
    parameter int H_ACT_START  = 1,
    parameter int H_ACT_END    = 290,
    parameter int H_SYNC_START = 311,
    parameter int H_SYNC_END   = 342,
    parameter int H_JUMP_FROM  = 342,
    parameter int H_JUMP_TO    = 471,
    parameter int V_ACT_END    = 223,
    parameter int V_SYNC_START = 234,
    parameter int V_SYNC_END   = 241,
    parameter int V_JUMP_FROM  = 241,
    parameter int V_JUMP_TO    = 491
) (
    input  logic                 mclk_i,
    input  logic                 rst_i,
    arcade_video_timing_if.slave vid
);
    localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [CW-1:0] CNT_LAST = '1;

    localparam logic [CW-1:0] HAS = CW'(H_ACT_START);
    localparam logic [CW-1:0] HAE = CW'(H_ACT_END);
    localparam logic [CW-1:0] HSS = CW'(H_SYNC_START);
    localparam logic [CW-1:0] HSE = CW'(H_SYNC_END);
    localparam logic [CW-1:0] HJF = CW'(H_JUMP_FROM);
    localparam logic [CW-1:0] HJT = CW'(H_JUMP_TO);
    localparam logic [CW-1:0] VAE = CW'(V_ACT_END);
    localparam logic [CW-1:0] VSS = CW'(V_SYNC_START);
    localparam logic [CW-1:0] VSE = CW'(V_SYNC_END);
    localparam logic [CW-1:0] VJF = CW'(V_JUMP_FROM);
    localparam logic [CW-1:0] VJT = CW'(V_JUMP_TO);

    function automatic logic [CW-1:0] sext_trim(input logic [3:0] t);
        return {{(CW-4){t[3]}}, t};
    endfunction

    logic [DW-1:0]   div_q, div_d;
    logic            pce_q, pce_d;
    logic            pclk_q, pclk_d;
    logic [CW-1:0]   hcnt_q, hcnt_d;
    logic [CW-1:0]   vcnt_q, vcnt_d;
    logic            hblk_q, hblk_d;
    logic            vblk_q, vblk_d;
    logic            hsyn_q, hsyn_d;
    logic            vsyn_q, vsyn_d;
    logic            irq_q, irq_d;
    logic            odd_q, odd_d;
    logic [3:0]      ht_q, ht_d;
    logic [3:0]      vt_q, vt_d;
    logic [RGBW-1:0] rgb_q, rgb_d;

    logic [CW-1:0]   h_sync_on, h_sync_off;
    logic [CW-1:0]   v_sync_on, v_sync_off;
    logic            line_end;
    logic            frame_start;

    // Trimmed sync positions wrap modulo 2^CW.
    assign h_sync_on   = HSS + sext_trim(ht_q);
    assign h_sync_off  = HSE + sext_trim(ht_q);
    assign v_sync_on   = VSS + sext_trim(vt_q);
    assign v_sync_off  = VSE + sext_trim(vt_q);
    assign line_end    = (hcnt_q == CNT_LAST);
    assign frame_start = line_end && (vcnt_q == CNT_LAST);

    always_comb begin
        div_d  = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
        pce_d  = (div_d == DIV_LAST);
        pclk_d = (div_d < DIV_HALF);
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        hblk_d = hblk_q;
        vblk_d = vblk_q;
        hsyn_d = hsyn_q;
        vsyn_d = vsyn_q;
        irq_d  = 1'b0;
        odd_d  = odd_q;
        ht_d   = ht_q;
        vt_d   = vt_q;
        rgb_d  = rgb_q;

        if (pce_q) begin
            if (line_end)            hcnt_d = '0;
            else if (hcnt_q == HJF)  hcnt_d = HJT;
            else                     hcnt_d = hcnt_q + CW'(1);

            if (hcnt_q == HAS)       hblk_d = 1'b0;
            else if (hcnt_q == HAE)  hblk_d = 1'b1;

            // Sync release wins so a jump landing on the sync start still ends the pulse.
            if ((hcnt_q == h_sync_off) || (hcnt_q == HJF)) hsyn_d = 1'b1;
            else if (hcnt_q == h_sync_on)                  hsyn_d = 1'b0;

            rgb_d = (hblk_q || vblk_q) ? '0 : vid.rgb_in;

            if (line_end) begin
                if (vcnt_q == CNT_LAST)  vcnt_d = '0;
                else if (vcnt_q == VJF)  vcnt_d = VJT;
                else                     vcnt_d = vcnt_q + CW'(1);

                if (vcnt_q == CNT_LAST) begin
                    vblk_d = 1'b0;
                end else if (vcnt_q == VAE) begin
                    vblk_d = 1'b1;
                    irq_d  = !vblk_q;
                end

                if ((vcnt_q == v_sync_off) || (vcnt_q == VJF)) vsyn_d = 1'b1;
                else if (vcnt_q == v_sync_on)                  vsyn_d = 1'b0;
            end

            if (frame_start) begin
                ht_d  = vid.h_trim;
                vt_d  = vid.v_trim;
                odd_d = !odd_q;
            end
        end
    end

    always_ff @(posedge mclk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q  <= '0;
            pce_q  <= 1'b0;
            pclk_q <= 1'b0;
            hcnt_q <= '0;
            vcnt_q <= '0;
            hblk_q <= 1'b1;
            vblk_q <= 1'b1;
            hsyn_q <= 1'b1;
            vsyn_q <= 1'b1;
            irq_q  <= 1'b0;
            odd_q  <= 1'b0;
            ht_q   <= '0;
            vt_q   <= '0;
            rgb_q  <= '0;
        end else begin
            div_q  <= div_d;
            pce_q  <= pce_d;
            pclk_q <= pclk_d;
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            hblk_q <= hblk_d;
            vblk_q <= vblk_d;
            hsyn_q <= hsyn_d;
            vsyn_q <= vsyn_d;
            irq_q  <= irq_d;
            odd_q  <= odd_d;
            ht_q   <= ht_d;
            vt_q   <= vt_d;
            rgb_q  <= rgb_d;
        end
    end

    assign vid.pce       = pce_q;
    assign vid.pclk      = pclk_q;
    assign vid.hpos      = hcnt_q;
    assign vid.vpos      = vcnt_q;
    assign vid.rgb_out   = rgb_q;
    assign vid.hblk      = hblk_q;
    assign vid.vblk      = vblk_q;
    assign vid.hsyn      = hsyn_q;
    assign vid.vsyn      = vsyn_q;
    assign vid.vbl_irq   = irq_q;
    assign vid.frame_odd = odd_q;
endmodule

// File: tb/tb_arcade_video_timing.sv
// Bench for arcade_video_timing: a default instance for divider/line timing and reset,
// and a short-frame instance (14 lines, CLK_DIV=2) for frame, trim and RGB blanking checks.
module tb_arcade_video_timing;
    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    int   n_chk = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    arcade_video_timing_if #(.CW(9), .RGBW(12)) va ();
    arcade_video_timing_if #(.CW(9), .RGBW(12)) vb ();

    arcade_video_timing u_a (
        .mclk_i (clk),
        .rst_i  (rst_a),
        .vid    (va)
    );

    arcade_video_timing #(
        .CLK_DIV      (2),
        .V_ACT_END    (5),
        .V_SYNC_START (6),
        .V_SYNC_END   (8),
        .V_JUMP_FROM  (9),
        .V_JUMP_TO    (508)
    ) u_b (
        .mclk_i (clk),
        .rst_i  (rst_b),
        .vid    (vb)
    );

    typedef struct {
        int         v;
        int         h;
        logic [11:0] rgb;
        logic [3:0]  ht;
        logic [3:0]  vt;
        logic        hblk;
        logic        vblk;
        logic        hsyn;
        logic        vsyn;
        logic [11:0] orgb;
    } vec_t;

    localparam int NV = 27;
    vec_t tv [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic expire(input string name);
        n_chk++;
        n_bad++;
        $display("FAIL %s: wait expired before the expected event", name);
    endtask

    task automatic wait_b(input int v, input int h, input int budget, output bit ok);
        int n;
        n = 0;
        while (!(int'(vb.vpos) == v && int'(vb.hpos) == h) && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (int'(vb.vpos) == v && int'(vb.hpos) == h);
        if (!ok) expire($sformatf("wait_b v%0d h%0d", v, h));
    endtask

    task automatic wait_a(input int h, input int budget, output bit ok);
        int n;
        n = 0;
        while (int'(va.hpos) != h && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (int'(va.hpos) == h);
        if (!ok) expire($sformatf("wait_a h%0d", h));
    endtask

    task automatic wait_a_leave(input int h, input int budget, output bit ok);
        int n;
        n = 0;
        while (int'(va.hpos) == h && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (int'(va.hpos) != h);
        if (!ok) expire($sformatf("leave h%0d", h));
    endtask

    initial begin
        // v, h, rgb_in, h_trim, v_trim | hblk vblk hsyn vsyn oRGB
        tv[0]  = '{0,   1,   12'hFFF, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000};
        tv[1]  = '{0,   2,   12'hFFF, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000};
        tv[2]  = '{0,   3,   12'hFFF, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 12'hFFF};
        tv[3]  = '{0,   100, 12'h5A3, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h5A3};
        tv[4]  = '{0,   291, 12'h123, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h123};
        tv[5]  = '{0,   292, 12'h123, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000};
        tv[6]  = '{0,   312, 12'h123, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h000};
        tv[7]  = '{0,   342, 12'h123, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h000};
        tv[8]  = '{0,   471, 12'h123, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000};
        tv[9]  = '{5,   3,   12'hFFF, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 12'hFFF};
        tv[10] = '{6,   3,   12'hFFF, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000};
        tv[11] = '{7,   0,   12'hFFF, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000};
        tv[12] = '{8,   200, 12'hFFF, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000};
        tv[13] = '{9,   0,   12'hFFF, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h000};
        tv[14] = '{508, 10,  12'hFFF, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000};
        tv[15] = '{0,   3,   12'hFFF, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 12'hFFF};
        tv[16] = '{6,   0,   12'hFFF, 4'h3, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 12'h000};
        tv[17] = '{6,   312, 12'hFFF, 4'h3, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 12'h000};
        tv[18] = '{7,   0,   12'hFFF, 4'h3, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000};
        tv[19] = '{0,   314, 12'hFFF, 4'h3, 4'hF, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000};
        tv[20] = '{0,   315, 12'hFFF, 4'h3, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 12'h000};
        tv[21] = '{0,   342, 12'hFFF, 4'h3, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 12'h000};
        tv[22] = '{0,   471, 12'hFFF, 4'h3, 4'hF, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000};
        tv[23] = '{5,   100, 12'hFFF, 4'h3, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 12'hFFF};
        tv[24] = '{6,   0,   12'hFFF, 4'h3, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000};
        tv[25] = '{7,   200, 12'hFFF, 4'h3, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000};
        tv[26] = '{8,   0,   12'hFFF, 4'h3, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 12'h000};

        va.h_trim = 4'h0;
        va.v_trim = 4'h0;
        va.rgb_in = 12'hABC;
        vb.h_trim = 4'h0;
        vb.v_trim = 4'h0;
        vb.rgb_in = 12'hFFF;

        #1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(negedge clk);
        check("rst_a flags", 32'({va.pce, va.pclk, va.hblk, va.vblk, va.hsyn, va.vsyn,
                                  va.vbl_irq, va.frame_odd}), 32'h3C);
        check("rst_a pos", 32'({va.vpos, va.hpos}), 32'h0);
        check("rst_a rgb", 32'(va.rgb_out), 32'h0);
        check("rst_b flags", 32'({vb.pce, vb.pclk, vb.hblk, vb.vblk, vb.hsyn, vb.vsyn,
                                  vb.vbl_irq, vb.frame_odd}), 32'h3C);
        rst_a = 1'b0;
        rst_b = 1'b0;

        fork
            begin : seq_a
                bit ok;
                bit ph;
                int n, pc, nf, per, wid;
                for (int k = 1; k <= 24; k++) begin
                    @(negedge clk);
                    check($sformatf("pce k%0d", k), 32'(va.pce), 32'((k % 8) == 7));
                    check($sformatf("pclk k%0d", k), 32'(va.pclk), 32'((k % 8) < 4));
                    check($sformatf("hpos k%0d", k), 32'(va.hpos), 32'(k / 8));
                    if (k == 15 || k == 16)
                        check($sformatf("hblk k%0d", k), 32'(va.hblk), 32'(k < 16));
                end

                n = 0; pc = 0; nf = 0; per = -1; wid = -1;
                ph = va.hsyn;
                while (nf < 2 && n < 8000) begin
                    @(negedge clk);
                    n++;
                    if (ph && !va.hsyn) begin
                        nf++;
                        if (nf == 2) per = pc;
                        pc = 0;
                    end
                    if (!ph && va.hsyn && nf == 1) wid = pc;
                    if (va.pce) pc++;
                    ph = va.hsyn;
                end
                if (nf < 2) expire("hsyn period");
                else begin
                    check("hsyn period", 32'(per), 32'd384);
                    check("hsyn width", 32'(wid), 32'd31);
                end

                wait_a(342, 4000, ok);
                if (ok) begin
                    wait_a_leave(342, 20, ok);
                    if (ok) check("hpos after 342", 32'(va.hpos), 32'd471);
                end
                wait_a(511, 4000, ok);
                if (ok) begin
                    wait_a_leave(511, 20, ok);
                    if (ok) check("hpos after 511", 32'({va.vpos, va.hpos}), 32'({9'd2, 9'd0}));
                end

                wait_a(200, 4000, ok);
                if (ok) begin
                    rst_a = 1'b1;
                    #1;
                    check("midrst pos", 32'({va.vpos, va.hpos}), 32'h0);
                    check("midrst flags", 32'({va.pce, va.pclk, va.hblk, va.vblk, va.hsyn,
                                               va.vsyn, va.vbl_irq, va.frame_odd}), 32'h3C);
                    @(negedge clk);
                    rst_a = 1'b0;
                    for (int k = 1; k <= 8; k++) begin
                        @(negedge clk);
                        if (k >= 7) check($sformatf("restart hpos k%0d", k), 32'(va.hpos), 32'(k / 8));
                    end
                end
            end

            begin : seq_b
                bit ok;
                bit pv, ph, po, found, done;
                int n, hs, vp, irq, tog;
                wait_b(511, 0, 20000, ok);
                for (int i = 0; i < NV; i++) begin
                    vb.rgb_in = tv[i].rgb;
                    vb.h_trim = tv[i].ht;
                    vb.v_trim = tv[i].vt;
                    wait_b(tv[i].v, tv[i].h, 20000, ok);
                    if (ok)
                        check($sformatf("vec%0d v%0d h%0d", i, tv[i].v, tv[i].h),
                              32'({vb.hblk, vb.vblk, vb.hsyn, vb.vsyn, vb.rgb_out}),
                              32'({tv[i].hblk, tv[i].vblk, tv[i].hsyn, tv[i].vsyn, tv[i].orgb}));
                end

                // One full frame measured between consecutive VSYN falls.
                n = 0; found = 1'b0;
                pv = vb.vsyn;
                while (!found && n < 15000) begin
                    @(negedge clk);
                    n++;
                    if (pv && !vb.vsyn) found = 1'b1;
                    pv = vb.vsyn;
                end
                if (!found) expire("vsyn first fall");
                else begin
                    n = 0; hs = 0; vp = 0; irq = 0; tog = 0; done = 1'b0;
                    ph = vb.hsyn; po = vb.frame_odd; pv = vb.vsyn;
                    while (!done && n < 15000) begin
                        if (vb.pce && vb.vblk) vp++;
                        if (vb.vbl_irq) irq++;
                        @(negedge clk);
                        n++;
                        if (ph && !vb.hsyn) hs++;
                        if (po != vb.frame_odd) tog++;
                        if (pv && !vb.vsyn) done = 1'b1;
                        ph = vb.hsyn; po = vb.frame_odd; pv = vb.vsyn;
                    end
                    if (!done) expire("vsyn second fall");
                    else begin
                        check("hsyn per frame", 32'(hs), 32'd14);
                        check("vblk pixels", 32'(vp), 32'd3072);
                        check("vbl_irq cycles", 32'(irq), 32'd1);
                        check("frame_odd toggles", 32'(tog), 32'd1);
                    end
                end

                wait_b(7, 200, 15000, ok);
                if (ok) begin
                    rst_b = 1'b1;
                    #1;
                    check("b midrst pos", 32'({vb.vpos, vb.hpos}), 32'h0);
                    check("b midrst flags", 32'({vb.pce, vb.pclk, vb.hblk, vb.vblk, vb.hsyn,
                                                 vb.vsyn, vb.vbl_irq, vb.frame_odd}), 32'h3C);
                    @(negedge clk);
                    rst_b = 1'b0;
                    wait_b(0, 311, 2000, ok);
                    if (ok) check("trim cleared h311", 32'(vb.hsyn), 32'd1);
                    wait_b(0, 312, 100, ok);
                    if (ok) check("trim cleared h312", 32'(vb.hsyn), 32'd0);
                end
            end
        join

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
